// File: rtl/fb_line_reader_pkg.sv
// Shared display package: framebuffer geometry defaults and the line-reader state encoding.
package fb_line_reader_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 320;
  localparam int unsigned FB_HEIGHT_DEF = 180;
  localparam int unsigned FB_SCALE_DEF  = 2;

  // Scale counter is sized for the largest supported FB_SCALE (63).
  localparam int unsigned SCALE_CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fb_rd_state_t;

endpackage

// File: rtl/fb_line_reader_rd_align.sv
// LAT-deep enable delay line matching BRAM read latency; synchronous flush clears all stages.
module fb_rd_align #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic en_i,
  output logic en_o
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  generate
    if (LAT == 1) begin : g_single
      assign sr_d = flush_i ? 1'b0 : en_i;
    end else begin : g_multi
      assign sr_d = flush_i ? '0 : {sr_q[LAT-2:0], en_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign en_o = sr_q[LAT-1];

endmodule

// File: rtl/fb_line_reader.sv
// Streams framebuffer rows into the display linebuffer, one row per FB_SCALE display lines.
module fb_line_reader
  import fb_line_reader_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int unsigned FB_SCALE  = FB_SCALE_DEF,
  parameter int unsigned ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT),
  parameter int unsigned DATAW     = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame,
  input  logic                         line,
  input  logic                         line0,
  input  logic [DATAW-1:0]             fb_data,
  output logic [ADDRW-1:0]             fb_addr,
  output logic                         lb_en,
  output logic [DATAW-1:0]             lb_data,
  output logic [$clog2(FB_HEIGHT)-1:0] row,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int unsigned XW   = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int unsigned ROWW = $clog2(FB_HEIGHT);
  localparam int unsigned SCW  = SCALE_CW;

  localparam logic [XW-1:0]    X_LAST      = XW'(FB_WIDTH - 1);
  localparam logic [ROWW-1:0]  ROW_LAST    = ROWW'(FB_HEIGHT - 1);
  localparam logic [SCW-1:0]   SC_LAST     = SCW'(FB_SCALE - 1);
  localparam logic [ADDRW-1:0] ADDR_STRIDE = ADDRW'(FB_WIDTH);

  fb_rd_state_t     state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [XW-1:0]    x_q, x_d;
  logic [ROWW-1:0]  row_q, row_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic             issue_c;
  logic             flush_c;
  logic             line_c;
  logic             sc_wrap_c;
  logic [ADDRW-1:0] next_base_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      row_q   <= '0;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      row_q   <= row_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    x_d         = x_q;
    row_d       = row_q;
    sc_d        = sc_q;
    ovr_d       = ovr_q;
    done_d      = 1'b0;
    flush_c     = 1'b0;
    line_c      = 1'b0;
    sc_wrap_c   = (sc_q == SC_LAST);
    next_base_c = addr_q + (ADDR_STRIDE - ADDRW'(x_q));

    if (frame) begin
      state_d = IDLE;
      addr_d  = '0;
      x_d     = '0;
      row_d   = '0;
      sc_d    = '0;
      ovr_d   = 1'b0;
      flush_c = 1'b1;
    end else if (line0) begin
      state_d = READ;
      addr_d  = '0;
      x_d     = '0;
      row_d   = '0;
      sc_d    = '0;
    end else begin
      case (state_q)
        READ: begin
          if (line) begin
            // Late line: drop the rest of the row and jump to the next row base.
            ovr_d  = 1'b1;
            line_c = 1'b1;
            if (row_q != ROW_LAST) addr_d = next_base_c;
          end else if (x_q == X_LAST) begin
            state_d = WAIT;
            x_d     = '0;
            if (row_q != ROW_LAST) addr_d = addr_q + ADDRW'(1);
          end else begin
            x_d    = x_q + XW'(1);
            addr_d = addr_q + ADDRW'(1);
          end
        end
        WAIT:    line_c = line;
        default: ;
      endcase
    end

    // Line-period advance shared by WAIT and the overrun path.
    if (line_c) begin
      x_d     = '0;
      sc_d    = sc_wrap_c ? '0 : sc_q + SCW'(1);
      state_d = WAIT;
      if (sc_wrap_c) begin
        if (row_q != ROW_LAST) begin
          row_d   = row_q + ROWW'(1);
          state_d = READ;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d == READ) || (state_d == WAIT);
  end

  assign issue_c = (state_q == READ);

  fb_rd_align #(
    .LAT(RD_LAT)
  ) u_align (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush_c),
    .en_i   (issue_c),
    .en_o   (lb_en)
  );

  assign fb_addr    = addr_q;
  assign row        = row_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign lb_data    = fb_data;

endmodule
